// File: rtl/elevator_sched.sv
// Elevator car scheduler: latches floor calls, chooses travel direction with a
// SCAN (keep-direction) policy, and sequences the motor and door with internal
// travel and door-dwell timers. All outputs come straight from flops.
module elevator_sched #(
  parameter int N_FLOORS      = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic                 dir_q, dir_d;
  logic [N_FLOORS-1:0]  pending_q, pending_d;
  logic                 motorUp_q, motorDown_q, door_q, busy_q;

  logic [FLOOR_W-1:0]   upFloor, dnFloor;
  logic                 pendAbove, pendBelow, beyondUp, beyondDn;

  // Summarise outstanding calls relative to the current floor and to the
  // floor the car would reach next in either direction.
  always_comb begin
    upFloor   = floor_q + FLOOR_W'(1);
    dnFloor   = floor_q - FLOOR_W'(1);
    pendAbove = 1'b0;
    pendBelow = 1'b0;
    beyondUp  = 1'b0;
    beyondDn  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor_q) pendAbove = pendAbove | pending_q[i];
      if (FLOOR_W'(i) < floor_q) pendBelow = pendBelow | pending_q[i];
      if (FLOOR_W'(i) > upFloor) beyondUp  = beyondUp  | pending_q[i];
      if (FLOOR_W'(i) < dnFloor) beyondDn  = beyondDn  | pending_q[i];
    end
  end

  // Next-state logic: SCAN decision in IDLE, floor stepping while moving,
  // door dwell with reload on a repeated call for the current floor.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    pending_d = pending_q | call_req;

    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = DOOR;
          timer_d = DOOR_LOAD;
        end else if (dir_q && pendAbove) begin
          state_d = MOVE_UP;
          timer_d = TRAVEL_LOAD;
        end else if (pendBelow) begin
          state_d = MOVE_DOWN;
          timer_d = TRAVEL_LOAD;
          dir_d   = 1'b0;
        end else if (pendAbove) begin
          state_d = MOVE_UP;
          timer_d = TRAVEL_LOAD;
          dir_d   = 1'b1;
        end
      end
      MOVE_UP: begin
        if (timer_q == '0) begin
          floor_d = upFloor;
          if (pending_q[upFloor]) begin
            state_d = DOOR;
            timer_d = DOOR_LOAD;
          end else if (beyondUp) begin
            timer_d = TRAVEL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      MOVE_DOWN: begin
        if (timer_q == '0) begin
          floor_d = dnFloor;
          if (pending_q[dnFloor]) begin
            state_d = DOOR;
            timer_d = DOOR_LOAD;
          end else if (beyondDn) begin
            timer_d = TRAVEL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DOOR: begin
        if (call_req[floor_q]) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A call for the floor whose door is open is already being served.
    if (state_q == DOOR) pending_d[floor_q] = pending_q[floor_q];
    if (state_d == DOOR && state_q != DOOR) pending_d[floor_d] = 1'b0;
  end

  // State, timer, position and registered output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      pending_q   <= '0;
      motorUp_q   <= 1'b0;
      motorDown_q <= 1'b0;
      door_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      motorUp_q   <= (state_d == MOVE_UP);
      motorDown_q <= (state_d == MOVE_DOWN);
      door_q      <= (state_d == DOOR);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign cur_floor  = floor_q;
  assign motor_up   = motorUp_q;
  assign motor_down = motorDown_q;
  assign door_open  = door_q;
  assign dir_up     = dir_q;
  assign pending    = pending_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_elevator_sched.sv
// Directed and randomised bench for the elevator scheduler (4 floors,
// 16-cycle travel, 8-cycle door dwell). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_elevator_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] call_req = 4'b0000;
  logic [1:0] cur_floor;
  logic       motor_up, motor_down, door_open, dir_up, busy;
  logic [3:0] pending;

  int checks = 0;
  int failures = 0;

  elevator_sched #(
    .N_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(16), .DOOR_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .cur_floor(cur_floor),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .dir_up(dir_up), .pending(pending), .busy(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe a call pattern for exactly one rising edge; returns one negedge later.
  task automatic applyStimulus(input logic [3:0] req);
    call_req = req;
    @(negedge clk);
    call_req = 4'b0000;
  endtask

  // Wait (bounded) until the car is idle with nothing outstanding.
  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy !== 1'b0 || pending !== 4'b0000) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n >= 400), 32'd0);
  endtask

  initial begin
    int upCnt, doorCnt, maxAge;
    int age [4];
    logic [4:0] viol;
    logic [3:0] req;

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst_cur_floor", 32'(cur_floor), 32'd0);
    checkOutput("rst_pending",   32'(pending),   32'd0);
    checkOutput("rst_dir_up",    32'(dir_up),    32'd1);
    checkOutput("rst_motors",    32'({motor_up, motor_down}), 32'd0);
    checkOutput("rst_door",      32'(door_open), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] door at current floor with re-strobe");
    applyStimulus(4'b0001);
    checkOutput("t3_pending", 32'(pending), 32'h1);
    checkOutput("t3_door_n1", 32'(door_open), 32'd0);
    @(negedge clk);
    checkOutput("t3_door_n2", 32'(door_open), 32'd1);
    checkOutput("t3_motors",  32'({motor_up, motor_down}), 32'd0);
    checkOutput("t3_clear",   32'(pending), 32'd0);
    checkOutput("t3_busy",    32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    applyStimulus(4'b0001);
    checkOutput("t3_no_set",  32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_door_n10", 32'(door_open), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("t3_door_n14", 32'(door_open), 32'd1);
    @(negedge clk);
    checkOutput("t3_door_n15", 32'(door_open), 32'd0);
    checkOutput("t3_idle",     32'(busy), 32'd0);

    $display("[TB] floor 0 to floor 3");
    applyStimulus(4'b1000);
    checkOutput("t2_pending", 32'(pending), 32'h8);
    checkOutput("t2_motor_n1", 32'(motor_up), 32'd0);
    upCnt = 0;
    doorCnt = 0;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      if (motor_up === 1'b1) upCnt++;
      if (door_open === 1'b1) doorCnt++;
      case (c)
        2:  begin
              checkOutput("t2_start_up",  32'(motor_up), 32'd1);
              checkOutput("t2_start_bsy", 32'(busy), 32'd1);
            end
        17: checkOutput("t2_floor_c17", 32'(cur_floor), 32'd0);
        18: checkOutput("t2_floor_c18", 32'(cur_floor), 32'd1);
        34: checkOutput("t2_floor_c34", 32'(cur_floor), 32'd2);
        49: checkOutput("t2_up_c49",    32'({cur_floor, motor_up}), 32'b101);
        50: begin
              checkOutput("t2_arrive",    32'({cur_floor, motor_up, door_open}), 32'b1101);
              checkOutput("t2_pend_clr",  32'(pending), 32'd0);
            end
        58: checkOutput("t2_done", 32'({busy, door_open}), 32'd0);
        default: ;
      endcase
    end
    checkOutput("t2_up_cycles",   32'(upCnt),   32'd48);
    checkOutput("t2_door_cycles", 32'(doorCnt), 32'd8);
    checkOutput("t2_dir",         32'(dir_up),  32'd1);

    $display("[TB] return to floor 0");
    applyStimulus(4'b0001);
    waitIdle("go_floor0_timeout");
    checkOutput("go0_floor", 32'(cur_floor), 32'd0);
    checkOutput("go0_dir",   32'(dir_up),    32'd0);

    $display("[TB] en-route pickup");
    applyStimulus(4'b1000);
    for (int c = 2; c <= 67; c++) begin
      @(negedge clk);
      case (c)
        2:  checkOutput("t4_up_dir", 32'({motor_up, dir_up}), 32'b11);
        6:  call_req = 4'b0010;
        7:  begin
              call_req = 4'b0000;
              checkOutput("t4_pend_both", 32'(pending), 32'ha);
            end
        17: checkOutput("t4_c17", 32'({cur_floor, motor_up}), 32'b001);
        18: begin
              checkOutput("t4_stop1", 32'({cur_floor, motor_up, door_open}), 32'b0101);
              checkOutput("t4_stop1_pend", 32'(pending), 32'h8);
            end
        25: checkOutput("t4_door_c25", 32'(door_open), 32'd1);
        26: checkOutput("t4_idle_c26", 32'({busy, door_open, pending}), 32'h08);
        27: checkOutput("t4_resume",   32'(motor_up), 32'd1);
        43: checkOutput("t4_pass2",    32'({cur_floor, motor_up, door_open}), 32'b1010);
        58: checkOutput("t4_c58",      32'({cur_floor, motor_up}), 32'b101);
        59: begin
              checkOutput("t4_stop3", 32'({cur_floor, door_open}), 32'b111);
              checkOutput("t4_stop3_pend", 32'(pending), 32'd0);
            end
        67: checkOutput("t4_done", 32'(busy), 32'd0);
        default: ;
      endcase
    end

    $display("[TB] position car at floor 1 heading up");
    applyStimulus(4'b0001);
    waitIdle("go_floor0b_timeout");
    applyStimulus(4'b0010);
    waitIdle("go_floor1_timeout");
    checkOutput("pos_floor1", 32'({cur_floor, dir_up}), 32'b011);

    $display("[TB] SCAN with calls above and below");
    applyStimulus(4'b0101);
    checkOutput("t5_pending", 32'(pending), 32'h5);
    for (int c = 2; c <= 67; c++) begin
      @(negedge clk);
      case (c)
        2:  checkOutput("t5_goes_up", 32'({motor_up, motor_down}), 32'b10);
        18: begin
              checkOutput("t5_stop2", 32'({cur_floor, door_open, dir_up}), 32'b1011);
              checkOutput("t5_stop2_pend", 32'(pending), 32'h1);
            end
        26: checkOutput("t5_idle2", 32'({busy, dir_up}), 32'b01);
        27: checkOutput("t5_goes_down", 32'({motor_down, dir_up}), 32'b10);
        43: checkOutput("t5_pass1", 32'({cur_floor, motor_down}), 32'b011);
        59: begin
              checkOutput("t5_stop0", 32'({cur_floor, door_open}), 32'b001);
              checkOutput("t5_stop0_pend", 32'(pending), 32'd0);
            end
        67: checkOutput("t5_done", 32'(busy), 32'd0);
        default: ;
      endcase
    end

    $display("[TB] async reset mid-move");
    applyStimulus(4'b1000);
    repeat (19) @(negedge clk);
    checkOutput("t1_pre_move", 32'({cur_floor, motor_up, dir_up}), 32'b0111);
    checkOutput("t1_pre_pend", 32'(pending), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_floor",   32'(cur_floor), 32'd0);
    checkOutput("t1_pending", 32'(pending),   32'd0);
    checkOutput("t1_outputs", 32'({motor_up, motor_down, door_open, busy}), 32'd0);
    checkOutput("t1_dir",     32'(dir_up),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1_after", 32'({busy, cur_floor}), 32'd0);

    $display("[TB] random call stress");
    maxAge = 0;
    for (int i = 0; i < 4; i++) age[i] = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      viol = {motor_up & motor_down,
              (motor_up | motor_down) & door_open,
              motor_up & (cur_floor == 2'd3),
              motor_down & (cur_floor == 2'd0),
              busy != (motor_up | motor_down | door_open)};
      checkOutput("invariant", 32'(viol), 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (pending[i]) age[i]++;
        else age[i] = 0;
        if (age[i] > maxAge) maxAge = age[i];
      end
      req = 4'b0000;
      if ($urandom_range(0, 9) == 0) req[2'($urandom_range(0, 3))] = 1'b1;
      if (door_open) req[cur_floor] = 1'b0;
      call_req = req;
    end
    call_req = 4'b0000;
    waitIdle("stress_drain_timeout");
    checkOutput("stress_pending", 32'(pending), 32'd0);
    checkOutput("service_bound", 32'(maxAge > 156), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
